// File: rtl/app_loopback_pkg.sv
// Shared types, constants and the per-byte transform for the loopback block.
package app_loopback_pkg;

    // Width of the activity LED stretch counter.
    localparam int ACT_BITS = 20;

    typedef enum logic [1:0] {
        MODE_PASS      = 2'd0,
        MODE_CASE_SWAP = 2'd1,
        MODE_DIGIT_INC = 2'd2,
        MODE_RSVD      = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_RELEASE
    } hold_state_e;

    // Transform one byte according to the selected mode; the reserved mode passes.
    function automatic logic [7:0] xform_byte(input logic [1:0] mode, input logic [7:0] b);
        logic [7:0] r;
        r = b;
        case (mode)
            MODE_CASE_SWAP: begin
                if (b >= 8'h41 && b <= 8'h5A)      r = b + 8'h20;
                else if (b >= 8'h61 && b <= 8'h7A) r = b - 8'h20;
            end
            MODE_DIGIT_INC: begin
                if (b >= 8'h30 && b <= 8'h38) r = b + 8'h01;
                else if (b == 8'h39)          r = 8'h30;
            end
            default: r = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/app_loopback_if.sv
// OUT (host->device) and IN (device->host) byte stream handshakes.
// The slave side is the loopback block, the master side is usb_cdc.
interface app_loopback_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] out_data_i;
    logic             out_valid_i;
    logic             out_ready_o;
    logic [WIDTH-1:0] in_data_o;
    logic             in_valid_o;
    logic             in_ready_i;

    modport slave (
        input  out_data_i, out_valid_i, in_ready_i,
        output out_ready_o, in_data_o, in_valid_o
    );

    modport master (
        output out_data_i, out_valid_i, in_ready_i,
        input  out_ready_o, in_data_o, in_valid_o
    );
endinterface

// File: rtl/app_loopback_fifo_sync.sv
// Synchronous FIFO with wrap-bit pointers and an asynchronous-read memory.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [$clog2(DEPTH):0]   level_next_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Next pointer values; flush overrides any push or pop.
    // NOTE: combinational blocks use blocking '=', clocked blocks use '<=' only.
    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + (AW+1)'(1);
            if (pop_i)  rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage write port.
    // NOTE: the array has no reset so it maps onto BRAM/LUT RAM; empty/valid guard its contents.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o      = mem_q[rptr_q[AW-1:0]];
    assign empty_o      = (wptr_q == rptr_q);
    assign full_o       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign level_o      = wptr_q - rptr_q;
    assign level_next_o = wptr_d - rptr_d;
endmodule

// File: rtl/app_loopback.sv
// USB CDC loopback: transform OUT bytes, queue them, optionally coalesce
// into IN bursts, and stretch transfer activity onto an LED.
module app_loopback
    import app_loopback_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 16,
    parameter int HOLD_CYCLES = 0
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic [1:0]             mode_i,
    input  logic                   flush_i,
    app_loopback_if.slave          bus,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   activity_o
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
    localparam logic [LW-1:0] HALF     = LW'(DEPTH / 2);

    logic             full, empty, push, pop, release_w;
    logic [LW-1:0]    level_next;
    logic [WIDTH-1:0] wr_data;

    hold_state_e        state_q;
    logic [HW-1:0]      hold_cnt_q;
    logic [ACT_BITS-1:0] act_cnt_q, act_cnt_d;

    assign bus.out_ready_o = !full && !flush_i;
    assign push            = bus.out_valid_i && bus.out_ready_o;
    assign release_w       = (HOLD_CYCLES == 0) || (state_q == ST_RELEASE);
    assign bus.in_valid_o  = !empty && release_w;
    assign pop             = bus.in_valid_o && bus.in_ready_i;

    // Transform the low byte with the mode seen in the accept cycle; upper bits pass.
    always_comb begin
        wr_data      = bus.out_data_i;
        wr_data[7:0] = xform_byte(mode_i, bus.out_data_i[7:0]);
    end

    fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .flush_i      (flush_i),
        .push_i       (push),
        .pop_i        (pop),
        .wdata_i      (wr_data),
        .rdata_o      (bus.in_data_o),
        .full_o       (full),
        .empty_o      (empty),
        .level_o      (level_o),
        .level_next_o (level_next)
    );

    // Hold/release FSM: wait for an idle gap or half-full before opening the IN side.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
        end else if (flush_i) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (push) begin
                        hold_cnt_q <= '0;
                        state_q    <= (level_next >= HALF) ? ST_RELEASE : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_MAX || level_next >= HALF) begin
                        state_q    <= ST_RELEASE;
                        hold_cnt_q <= '0;
                    end else if (push) begin
                        hold_cnt_q <= '0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (level_next == '0) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Activity stretch: any transfer reloads the counter, otherwise count down to zero.
    always_comb begin
        act_cnt_d = act_cnt_q;
        if (push || pop)           act_cnt_d = '1;
        else if (act_cnt_q != '0)  act_cnt_d = act_cnt_q - ACT_BITS'(1);
    end

    // Activity counter register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) act_cnt_q <= '0;
        else         act_cnt_q <= act_cnt_d;
    end

    assign activity_o = (act_cnt_q != '0);
endmodule

// File: tb/tb_app_loopback.sv
// Self-checking bench for app_loopback: one instance without holding, one
// with HOLD_CYCLES=100. Inputs change 1 ns after the rising edge, outputs
// are sampled there too.
module tb_app_loopback;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] din;
        logic [7:0] dout;
    } vec_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] mode_a, mode_h;
    logic       flush_a, flush_h;
    logic [4:0] level_a, level_h;
    logic       act_a, act_h;

    app_loopback_if #(.WIDTH(8)) bus_a ();
    app_loopback_if #(.WIDTH(8)) bus_h ();

    app_loopback #(.WIDTH(8), .DEPTH(16), .HOLD_CYCLES(0)) u_dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .mode_i     (mode_a),
        .flush_i    (flush_a),
        .bus        (bus_a),
        .level_o    (level_a),
        .activity_o (act_a)
    );

    app_loopback #(.WIDTH(8), .DEPTH(16), .HOLD_CYCLES(100)) u_dut_hold (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .mode_i     (mode_h),
        .flush_i    (flush_h),
        .bus        (bus_h),
        .level_o    (level_h),
        .activity_o (act_h)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         pops     = 0;
    bit         chk_stress = 1'b0;
    logic [7:0] exp_q[$];
    vec_t       vecs[16];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] ref_xform(input logic [1:0] m, input logic [7:0] b);
        if (m == 2'd1 && ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A))) return b ^ 8'h20;
        if (m == 2'd2 && b == 8'h39) return 8'h30;
        if (m == 2'd2 && b >= 8'h30 && b < 8'h39) return b + 8'd1;
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string got, input string exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\", expected \"%s\"", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle on the no-hold instance, with the model tracking pushes and pops.
    task automatic cyc(input logic v, input logic [7:0] d, input logic [1:0] m, input logic r);
        logic acc, pp;
        bus_a.out_valid_i = v;
        bus_a.out_data_i  = d;
        mode_a            = m;
        bus_a.in_ready_i  = r;
        #1;
        acc = v & bus_a.out_ready_o;
        pp  = bus_a.in_valid_o & r;
        if (pp) begin
            pops++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_data: got 0x%0h, expected no data", bus_a.in_data_o);
            end else begin
                check("pop_data", bus_a.in_data_o, exp_q.pop_front());
            end
        end
        if (acc) exp_q.push_back(ref_xform(m, d));
        tick();
        if (chk_stress) begin
            check("stress_level", level_a, exp_q.size());
            if (acc || pp) check("stress_activity", act_a, 1);
        end
    endtask

    task automatic drain_a(input int budget);
        int k = 0;
        while (exp_q.size() > 0 && k < budget) begin
            cyc(1'b0, 8'h00, 2'd0, 1'b1);
            k++;
        end
        check("drain_remaining", exp_q.size(), 0);
        check("drain_level", level_a, 0);
    endtask

    task automatic send_str(input string s, input logic [1:0] m);
        for (int i = 0; i < s.len(); i++) cyc(1'b1, s[i], m, 1'b0);
    endtask

    task automatic recv_str(input int n, output string got);
        int k = 0;
        got = "";
        while (got.len() < n && k < 50) begin
            if (bus_a.in_valid_o) got = $sformatf("%s%c", got, bus_a.in_data_o);
            cyc(1'b0, 8'h00, 2'd0, 1'b1);
            k++;
        end
    endtask

    initial begin
        string      got;
        int         pops0, j, k, accepted, early;
        logic       acc_now, v, r;
        logic [1:0] m;
        logic [7:0] d;
        logic [7:0] hb[3];

        vecs[0]  = '{2'd0, 8'h41, 8'h41};
        vecs[1]  = '{2'd3, 8'h61, 8'h61};
        vecs[2]  = '{2'd1, 8'h40, 8'h40};
        vecs[3]  = '{2'd1, 8'h41, 8'h61};
        vecs[4]  = '{2'd1, 8'h5A, 8'h7A};
        vecs[5]  = '{2'd1, 8'h5B, 8'h5B};
        vecs[6]  = '{2'd1, 8'h60, 8'h60};
        vecs[7]  = '{2'd1, 8'h61, 8'h41};
        vecs[8]  = '{2'd1, 8'h7A, 8'h5A};
        vecs[9]  = '{2'd1, 8'h7B, 8'h7B};
        vecs[10] = '{2'd2, 8'h2F, 8'h2F};
        vecs[11] = '{2'd2, 8'h30, 8'h31};
        vecs[12] = '{2'd2, 8'h38, 8'h39};
        vecs[13] = '{2'd2, 8'h39, 8'h30};
        vecs[14] = '{2'd2, 8'h3A, 8'h3A};
        vecs[15] = '{2'd2, 8'h41, 8'h41};

        rstn = 1'b0;
        mode_a = 2'd0; mode_h = 2'd0; flush_a = 1'b0; flush_h = 1'b0;
        bus_a.out_valid_i = 1'b0; bus_a.out_data_i = '0; bus_a.in_ready_i = 1'b0;
        bus_h.out_valid_i = 1'b0; bus_h.out_data_i = '0; bus_h.in_ready_i = 1'b0;
        #1;
        check("rst_in_valid", bus_a.in_valid_o, 0);
        check("rst_level", level_a, 0);
        check("rst_activity", act_a, 0);
        check("rst_out_ready", bus_a.out_ready_o, 1);
        check("rst_hold_in_valid", bus_h.in_valid_o, 0);
        check("rst_hold_out_ready", bus_h.out_ready_o, 1);
        repeat (3) @(posedge clk);
        #3 rstn = 1'b1;
        tick();

        // Pass-through with one-cycle latency.
        pops0 = pops;
        cyc(1'b1, 8'h01, 2'd0, 1'b1);
        check("pt_first_valid", bus_a.in_valid_o, 1);
        check("pt_first_data", bus_a.in_data_o, 8'h01);
        check("pt_activity", act_a, 1);
        for (int i = 2; i <= 7; i++) cyc(1'b1, 8'(i), 2'd0, 1'b1);
        drain_a(20);
        check("pt_pop_count", pops - pops0, 7);

        // Transform vectors including range boundaries.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, vecs[i].din, vecs[i].mode, 1'b0);
            check($sformatf("vec%0d_valid", i), bus_a.in_valid_o, 1);
            check($sformatf("vec%0d_data", i), bus_a.in_data_o, vecs[i].dout);
            cyc(1'b0, 8'h00, 2'd0, 1'b1);
        end

        // Whole strings and a mid-stream mode switch.
        send_str("QRSTUVWX", 2'd1);
        recv_str(8, got);
        check_str("str_case_swap", got, "qrstuvwx");
        send_str("12345679", 2'd2);
        recv_str(8, got);
        check_str("str_digit_inc", got, "23456780");
        send_str("AB", 2'd0);
        send_str("CD", 2'd1);
        recv_str(4, got);
        check_str("str_mode_switch", got, "ABcd");
        check("str_level", level_a, 0);

        // Fill to full with the IN side blocked, then release.
        pops0 = pops;
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'h80 + 8'(i), 2'd0, 1'b0);
        check("full_out_ready", bus_a.out_ready_o, 0);
        check("full_level", level_a, 16);
        cyc(1'b1, 8'hEE, 2'd0, 1'b0);
        check("full_level_after_reject", level_a, 16);
        j = 16;
        k = 0;
        while ((j < 20 || exp_q.size() > 0) && k < 100) begin
            acc_now = bus_a.out_ready_o && (j < 20);
            cyc(j < 20, 8'h80 + 8'(j), 2'd0, 1'b1);
            if (acc_now) j++;
            k++;
        end
        check("full_all_accepted", j, 20);
        check("full_pop_count", pops - pops0, 20);
        check("full_level_end", level_a, 0);

        // Simultaneous push and pop keeps the level.
        cyc(1'b1, 8'h10, 2'd0, 1'b0);
        cyc(1'b1, 8'h11, 2'd0, 1'b1);
        check("push_pop_level", level_a, 1);
        drain_a(5);

        // Flush with five bytes queued; no push in the flush cycle.
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'h50 + 8'(i), 2'd0, 1'b0);
        check("flush_pre_level", level_a, 5);
        flush_a = 1'b1;
        bus_a.out_valid_i = 1'b1;
        bus_a.out_data_i  = 8'h77;
        #1;
        check("flush_out_ready", bus_a.out_ready_o, 0);
        tick();
        flush_a = 1'b0;
        bus_a.out_valid_i = 1'b0;
        #1;
        check("flush_level", level_a, 0);
        check("flush_in_valid", bus_a.in_valid_o, 0);
        exp_q.delete();
        cyc(1'b1, 8'h42, 2'd1, 1'b0);
        check("post_flush_data", bus_a.in_data_o, 8'h62);
        drain_a(5);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'h60 + 8'(i), 2'd0, 1'b0);
        cyc(1'b0, 8'h00, 2'd0, 1'b1);
        bus_a.in_ready_i = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("midrst_in_valid", bus_a.in_valid_o, 0);
        check("midrst_level", level_a, 0);
        check("midrst_activity", act_a, 0);
        check("midrst_out_ready", bus_a.out_ready_o, 1);
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        tick();
        cyc(1'b1, 8'h35, 2'd2, 1'b0);
        check("post_rst_valid", bus_a.in_valid_o, 1);
        check("post_rst_data", bus_a.in_data_o, 8'h36);
        drain_a(5);

        // Random stress against the model.
        chk_stress = 1'b1;
        accepted = 0;
        k = 0;
        while (accepted < 10000 && k < 60000) begin
            v = ($urandom_range(0, 99) < 70);
            r = ($urandom_range(0, 99) < 65);
            m = 2'($urandom_range(0, 3));
            d = $urandom_range(0, 1) ? 8'($urandom_range(8'h2F, 8'h7B)) : 8'($urandom_range(0, 255));
            if (v && bus_a.out_ready_o) accepted++;
            cyc(v, d, m, r);
            k++;
        end
        check("stress_accepted", accepted, 10000);
        drain_a(100);
        chk_stress = 1'b0;

        // Hold instance: three bytes, then an idle gap of HOLD_CYCLES.
        hb[0] = 8'h11; hb[1] = 8'h22; hb[2] = 8'h33;
        bus_h.in_ready_i = 1'b1;
        check("hold_out_ready", bus_h.out_ready_o, 1);
        for (int i = 0; i < 3; i++) begin
            bus_h.out_valid_i = 1'b1;
            bus_h.out_data_i  = hb[i];
            tick();
        end
        bus_h.out_valid_i = 1'b0;
        check("hold_k0_valid", bus_h.in_valid_o, 0);
        check("hold_level", level_h, 3);
        early = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (bus_h.in_valid_o) early++;
        end
        check("hold_early_valid_cycles", early, 0);
        tick();
        check("hold_release", bus_h.in_valid_o, 1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("hold_data%0d", i), bus_h.in_data_o, hb[i]);
            tick();
        end
        check("hold_drained_valid", bus_h.in_valid_o, 0);
        check("hold_drained_level", level_h, 0);

        // Hold instance: reaching DEPTH/2 releases without waiting.
        for (int i = 0; i < 8; i++) begin
            bus_h.out_valid_i = 1'b1;
            bus_h.out_data_i  = 8'hA0 + 8'(i);
            tick();
            if (i == 6) check("half_before_valid", bus_h.in_valid_o, 0);
        end
        bus_h.out_valid_i = 1'b0;
        check("half_release", bus_h.in_valid_o, 1);
        check("half_level", level_h, 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("half_data%0d", i), bus_h.in_data_o, 8'hA0 + 8'(i));
            tick();
        end
        check("half_drained_valid", bus_h.in_valid_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
